c_wf_alloc_sched: RTL

Request-holding scheduler placed in front of a wavefront allocator (`num_priorities`=2, `skip_empty_diags`=0). It accepts per-input output-port bid vectors over a valid/ready handshake and drives them into the allocator as a two-level priority request matrix. It holds each resulting one-hot grant until the requester consumes it, and pulses the allocator's priority `update`. Per-input age counters promote starved inputs to the high-priority level, so a bid that keeps losing is eventually served.

---
 rtl/c_wf_alloc_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/c_wf_alloc_sched.sv
// Request-holding scheduler in front of a two-level wavefront allocator.
// Holds bids until granted, holds grants until consumed, and promotes starved inputs.
module c_wf_alloc_sched #(
    parameter int unsigned num_ports    = 8,
    parameter int unsigned starve_limit = 15
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 active_i,
    input  logic [num_ports-1:0]                 req_valid_i,
    input  logic [num_ports*num_ports-1:0]       req_ports_i,
    output logic [num_ports-1:0]                 req_ready_o,
    output logic [2*num_ports*num_ports-1:0]     alloc_req_pr_o,
    input  logic [num_ports*num_ports-1:0]       alloc_gnt_i,
    output logic                                 alloc_update_o,
    output logic [num_ports-1:0]                 gnt_valid_o,
    output logic [num_ports*num_ports-1:0]       gnt_port_o,
    input  logic [num_ports-1:0]                 gnt_ready_i
);
    localparam int unsigned age_width = $clog2(starve_limit + 1);
    localparam int unsigned np2       = num_ports * num_ports;
    localparam logic [age_width-1:0] age_max = age_width'(starve_limit);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_GRANTED} state_e;

    state_e                 state_q    [num_ports];
    state_e                 state_d    [num_ports];
    logic [num_ports-1:0]   req_q      [num_ports];
    logic [num_ports-1:0]   req_d      [num_ports];
    logic [num_ports-1:0]   gnt_q      [num_ports];
    logic [num_ports-1:0]   gnt_d      [num_ports];
    logic [age_width-1:0]   age_q      [num_ports];
    logic [age_width-1:0]   age_d      [num_ports];
    logic [num_ports-1:0]   masked_req [num_ports];
    logic [num_ports-1:0]   eff_gnt    [num_ports];
    logic [num_ports-1:0]   eff_any;
    logic [num_ports-1:0]   busy_out;

    // Outputs currently held by a granted input are unavailable to everyone else.
    always_comb begin
        busy_out = '0;
        for (int i = 0; i < num_ports; i++) begin
            if (state_q[i] == ST_GRANTED) busy_out = busy_out | gnt_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < num_ports; i++) begin
            masked_req[i] = (state_q[i] == ST_PEND) ? (req_q[i] & ~busy_out) : '0;
            eff_gnt[i]    = masked_req[i] & alloc_gnt_i[i*num_ports +: num_ports];
            eff_any[i]    = |eff_gnt[i];
        end
    end

    // Everything visible outside is forced quiet while reset is asserted.
    always_comb begin
        req_ready_o    = '0;
        alloc_req_pr_o = '0;
        alloc_update_o = 1'b0;
        gnt_valid_o    = '0;
        gnt_port_o     = '0;
        if (reset_i) begin
            alloc_update_o = active_i & (|eff_any);
            for (int i = 0; i < num_ports; i++) begin
                req_ready_o[i] = active_i && (state_q[i] == ST_IDLE);
                if (age_q[i] == age_max) begin
                    alloc_req_pr_o[i*num_ports +: num_ports] = masked_req[i];
                end else begin
                    alloc_req_pr_o[np2 + i*num_ports +: num_ports] = masked_req[i];
                end
                gnt_valid_o[i] = (state_q[i] == ST_GRANTED);
                gnt_port_o[i*num_ports +: num_ports] = gnt_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < num_ports; i++) begin
            state_d[i] = state_q[i];
            req_d[i]   = req_q[i];
            gnt_d[i]   = gnt_q[i];
            age_d[i]   = age_q[i];
            if (active_i) begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        if (req_valid_i[i] && (|req_ports_i[i*num_ports +: num_ports])) begin
                            req_d[i]   = req_ports_i[i*num_ports +: num_ports];
                            age_d[i]   = '0;
                            state_d[i] = ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (eff_any[i]) begin
                            gnt_d[i]   = eff_gnt[i];
                            req_d[i]   = '0;
                            state_d[i] = ST_GRANTED;
                        end else if (age_q[i] != age_max) begin
                            age_d[i] = age_q[i] + age_width'(1);
                        end
                    end
                    ST_GRANTED: begin
                        if (gnt_ready_i[i]) begin
                            gnt_d[i]   = '0;
                            state_d[i] = ST_IDLE;
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_ports; i++) begin
            if (!reset_i) begin
                state_q[i] <= ST_IDLE;
                req_q[i]   <= '0;
                gnt_q[i]   <= '0;
                age_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                req_q[i]   <= req_d[i];
                gnt_q[i]   <= gnt_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

endmodule
